// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing helpers for the constant-time divider
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter width: counts 0..WIDTH-1 RUN edges.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] t;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  // A restored remainder is always below D, so its top bit is zero and
  // WIDTH bits suffice between iterations.
  always_comb begin
    r_shift  = {r_i, q_msb_i};
    t        = r_shift - {1'b0, d_i};
    q_bit_o  = ~t[WIDTH];
    r_next_o = q_bit_o ? t[WIDTH-1:0] : r_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_const_time.sv
// rtl/divider_const_time.sv - fixed-latency unsigned restoring divider (optional DIV_ZERO_FLAG_EN)
module divider_const_time
  import divider_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
`ifdef DIV_ZERO_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] r_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] q_d;

  // The step is evaluated every cycle regardless of state or operands.
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i      (r_q),
    .q_msb_i  (q_q[WIDTH-1]),
    .d_i      (d_q),
    .r_next_o (r_d),
    .q_bit_o  (q_bit_d)
  );

  assign q_d = {q_q[WIDTH-2:0], q_bit_d};

`ifdef DIV_ZERO_FLAG_EN
  logic dbz_q;

  // Zero-divisor flag tracks the divisor of the most recently accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      dbz_q <= (divisor == '0);
    end
  end

  assign div_by_zero = dbz_q;
`endif

  // Control FSM: fixed WIDTH RUN edges, no operand-dependent transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            count_q     <= '0;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_divider_const_time.sv
// tb/tb_divider_const_time.sv - directed self-checking bench for divider_const_time
module tb_divider_const_time;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   dividend, divisor;
  logic [7:0]   quotient, remainder;
  logic         busy, done;

  logic         start_w;
  logic [127:0] a0, b0, a1, b1;
  logic [127:0] q0, r0, q1, r1;
  logic         busy0, busy1, done0, done1;
`ifdef DIV_ZERO_FLAG_EN
  logic         dbz, dbz0, dbz1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  divider_const_time #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy),
`ifdef DIV_ZERO_FLAG_EN
    .div_by_zero(dbz),
`endif
    .done(done)
  );

  divider_const_time #(.WIDTH(128)) dut_w0 (
    .clk(clk), .rst(rst), .start(start_w), .dividend(a0), .divisor(b0),
    .quotient(q0), .remainder(r0), .busy(busy0),
`ifdef DIV_ZERO_FLAG_EN
    .div_by_zero(dbz0),
`endif
    .done(done0)
  );

  divider_const_time #(.WIDTH(128)) dut_w1 (
    .clk(clk), .rst(rst), .start(start_w), .dividend(a1), .divisor(b1),
    .quotient(q1), .remainder(r1), .busy(busy1),
`ifdef DIV_ZERO_FLAG_EN
    .div_by_zero(dbz1),
`endif
    .done(done1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a WIDTH=8 division, optionally re-asserting start mid-run, and check
  // the exact done cycle and the result.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input bit inject, input logic [7:0] eq, input logic [7:0] er);
    int bad;
    bad = 0;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = 8'hA5; divisor = 8'h5A;
    check({tag, "_busy_run"}, busy, 1);
    for (int i = 1; i < 8; i++) begin
      if (inject && i == 2) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (inject && i == 4) start = 1'b0;
      tick();
      if (done || !busy) bad++;
    end
    check({tag, "_no_early_done"}, bad, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    tick();
    check({tag, "_done_fall"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int bad, lat_bad, val_bad, t0, t1;
    logic [127:0] eq0, er0, eq1, er1;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start_w = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1;
    check("reset_outputs", {quotient, remainder, busy, done}, '0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_dbz", dbz, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    run8("d100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2);
    run8("d200_0", 8'd200, 8'd0, 1'b0, 8'd255, 8'd200);
`ifdef DIV_ZERO_FLAG_EN
    check("dbz_set", dbz, 1);
`endif
    run8("d255_1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("dbz_clear", dbz, 0);
`endif
    run8("d3_250", 8'd3, 8'd250, 1'b0, 8'd0, 8'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (quotient !== 8'd0 || remainder !== 8'd3 || done || busy) bad++;
    end
    check("hold_idle", bad, 0);

    run8("ignore_start", 8'd100, 8'd7, 1'b1, 8'd14, 8'd2);
    tick();

    // Reset during the fourth RUN cycle.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrun_reset", {quotient, remainder, busy, done}, '0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) bad++;
    end
    check("no_done_after_reset", bad, 0);
    run8("d9_4", 8'd9, 8'd4, 1'b0, 8'd2, 8'd1);

    // Paired 128-bit instances: done must land on the same, fixed cycle.
    bad = 0; lat_bad = 0; val_bad = 0;
    for (int it = 0; it < 300; it++) begin
      a0 = {$urandom, $urandom, $urandom, $urandom};
      a1 = {$urandom, $urandom, $urandom, $urandom};
      b0 = (it % 4 == 0) ? '0 : ({$urandom, $urandom, $urandom, $urandom} >> $urandom_range(127, 0));
      b1 = (it % 3 == 0) ? '0 : ({$urandom, $urandom, $urandom, $urandom} >> $urandom_range(127, 0));
      eq0 = (b0 == 0) ? '1 : a0 / b0;  er0 = (b0 == 0) ? a0 : a0 % b0;
      eq1 = (b1 == 0) ? '1 : a1 / b1;  er1 = (b1 == 0) ? a1 : a1 % b1;
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      t0 = 0; t1 = 0;
      for (int c = 1; c <= 200; c++) begin
        tick();
        if (done0 && t0 == 0) t0 = c;
        if (done1 && t1 == 0) t1 = c;
        if (t0 != 0 && t1 != 0) break;
      end
      if (t0 != t1) bad++;
      if (t0 != 128 || t1 != 128) lat_bad++;
      if (q0 !== eq0 || r0 !== er0 || q1 !== eq1 || r1 !== er1) val_bad++;
      tick();
    end
    check("pair_same_done_cycle", bad, 0);
    check("pair_latency_128", lat_bad, 0);
    check("pair_results", val_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
